regfile_multiport: RTL
======================

# regfile_multiport

Parametrised integer register file for the ID stage: configurable data width, address width and number of read ports, with registered reads and hardwired-zero entry 0. Entries are not reset in parallel. A sequential initialisation engine clears the array one entry per cycle after reset or on a soft-clear request, loads the stack pointer and global pointer, and then raises `ready`. Same-cycle write-to-read forwarding is a compile-time option.

## Interface
- `WIDTH`, 32, data width of each entry
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NRD`, 2, number of read ports (1..4)
- `SP_IDX`, 2, entry loaded with `init_sp` during initialisation
- `GP_IDX`, 3, entry loaded with `init_gp` during initialisation

Ports:
- `clk`  in  1  clock, all state updates on the rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `clr`  in  1  soft-clear request, sampled in RUN only
- `init_sp`  in  WIDTH  value loaded into entry SP_IDX
- `init_gp`  in  WIDTH  value loaded into entry GP_IDX
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  WIDTH  write data
- `rd_en`  in  NRD  per-port read enable
- `rd_addr`  in  NRD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- `rd_data`  out  NRD*WIDTH  packed registered read data; port i is bits [i*WIDTH +: WIDTH]
- `ready`  out  1  high in RUN, low in INIT

## Operation
- The block has two states, INIT and RUN. It also holds a pointer `ptr[ADDR_W-1:0]`.
- Reset (`rstn`=0 at an edge):
  - state goes to INIT and `ptr` to 0.
  - `ready` goes to 0 and all `rd_data` ports go to 0.
  - Array contents are not touched by reset itself.
- INIT, on each edge with `rstn`=1:
  - Entry `ptr` is written with `init_sp` if `ptr`==SP_IDX, `init_gp` if `ptr`==GP_IDX, otherwise 0.
  - `ptr` increments.
  - On the edge where `ptr`==2**ADDR_W-1, state goes to RUN and `ready` goes to 1.
- In INIT, `wr_en`, `rd_en` and `clr` are ignored and `rd_data` holds 0.
- RUN, write:
  - On an edge with `wr_en`=1 and `wr_addr`!=0, `RF[wr_addr]` is set to `wr_data`.
  - Writes to address 0 are discarded.
- RUN, read port i:
  - On an edge with `rd_en[i]`=1, `rd_data[i]` is set to `RF[rd_addr[i]]`.
  - If `rd_addr[i]`==0 the port loads 0.
  - With `rd_en[i]`=0 the port holds its previous value.
- All ports read independently. Any number of ports may read the same address in one cycle.
- RUN, `clr`=1 at an edge:
  - state goes to INIT, `ptr` to 0, `ready` to 0 and all `rd_data` to 0.
  - A `wr_en` in the same cycle is dropped.
- `init_sp`/`init_gp` are sampled on the edge at which `ptr` equals their index. They must be stable during INIT.

## Timing
- Read latency is 1 cycle: address presented before edge N, data valid after edge N.
- Write is visible to a read presented in the cycle after the writing edge.
- Initialisation takes exactly 2**ADDR_W edges with `rstn`=1 (32 at default). `ready` is high after the 32nd edge.
- Reset asserted mid-INIT restarts `ptr` at 0. The full sequence is repeated.
- Priority: `rstn` > `clr` > write/read.
- Outputs are registered. There are no combinational input-to-output paths.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: a port whose read collides with a write forwards that write. The conditions are `rd_en[i]`=1, `wr_en`=1, `wr_addr`!=0 and `rd_addr[i]`==`wr_addr` in the same RUN cycle. `rd_data[i]` then loads `wr_data` (write-first).
- Undefined: the same collision returns the pre-write value (read-first). The new value appears on the next read.
- Both variants write the array identically.

## Test plan
- Reset, then hold `rstn`=1 with `init_sp`=0x7FFF_FFF0 and `init_gp`=0x1000_8000 -> `ready` rises after exactly 32 edges. Reads of x2, x3 and x5 return 0x7FFF_FFF0, 0x1000_8000 and 0.
- Write x7=0xDEADBEEF, then read x7 on port 0 and x0 on port 1 the next cycle -> 0xDEADBEEF and 0. A later write of 0x1234 to x0 then reading x0 -> 0.
- Same-cycle write x9=0xA5A5A5A5 and read x9 on both ports, with x9 previously 0x11 -> 0xA5A5A5A5 with `REGFILE_BYPASS_EN`, 0x11 without. The following read gives 0xA5A5A5A5 in both variants.
- Read x7 on port 0, then deassert `rd_en[0]` for 3 cycles while `rd_addr` changes -> `rd_data[0]` stays 0xDEADBEEF.
- `clr` pulsed in the same cycle as a write of x7=0x5 -> `ready` falls next edge and the write is dropped. After 32 more edges x7 reads 0 and x2 reads `init_sp`.
- `rstn` pulsed low for 1 cycle at `ptr`=10 during INIT -> `ready` rises only after 32 further edges, with `rd_data`=0 throughout INIT.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport
// -----------------------------------------------------------------------------
// Integer register file for the ID stage.
// - Registered reads with 1-cycle latency. Entry 0 always reads as zero, and
//   writes to entry 0 are dropped.
// - The array has no parallel reset. After reset, or after a soft-clear
//   request, an init engine walks the array one entry per cycle:
//   - every entry is cleared, except SP_IDX and GP_IDX;
//   - SP_IDX is loaded with init_sp_i and GP_IDX with init_gp_i;
//   - ready_o is then raised.
//
// Compile-time option:
//   REGFILE_BYPASS_EN  When defined, a read that collides with a same-cycle
//                      write returns the new data (write-first). When
//                      undefined, it returns the stored data (read-first).
//
// Parameters:
//   WIDTH   data width of each entry
//   ADDR_W  address width, depth = 2**ADDR_W
//   NRD     number of read ports (1..4)
//   SP_IDX  entry loaded with init_sp_i during initialisation
//   GP_IDX  entry loaded with init_gp_i during initialisation
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   clr_i      soft-clear request, honoured in RUN only
//   init_sp_i  stack pointer init value (hold stable during INIT)
//   init_gp_i  global pointer init value (hold stable during INIT)
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    per-port read enable
//   rd_addr_i  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data_o  packed registered read data, port i at [i*WIDTH +: WIDTH]
//   ready_o    high in RUN, low while initialising
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned SP_IDX = 2,
    parameter int unsigned GP_IDX = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic [WIDTH-1:0]      init_sp_i,
    input  logic [WIDTH-1:0]      init_gp_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [NRD-1:0]        rd_en_i,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*WIDTH-1:0]  rd_data_o,
    output logic                  ready_o
);

    localparam int unsigned       Depth   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PtrLast = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SpAddr  = SP_IDX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] GpAddr  = GP_IDX[ADDR_W-1:0];

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Storage is deliberately not reset; the init engine clears it instead.
    logic [WIDTH-1:0]  rf_q [Depth];

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WIDTH-1:0]  arr_wdata;

    logic              run_active;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StInit;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StInit: begin
                // The pointer wraps to 0 on the last entry, so RUN starts with ptr = 0.
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == PtrLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr_i) begin
                    state_d = StInit;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                ptr_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready_o    = (state_q == StRun);
        // A clear in RUN takes priority over any read or write in the same cycle.
        run_active = (state_q == StRun) && !clr_i;
    end

    // -------------------------------------------------------------------------
    // Array write port, shared by the init engine and the functional write.
    // -------------------------------------------------------------------------
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = wr_addr_i;
        arr_wdata = wr_data_i;
        if (state_q == StInit) begin
            arr_we    = 1'b1;
            arr_waddr = ptr_q;
            if (ptr_q == SpAddr) begin
                arr_wdata = init_sp_i;
            end else if (ptr_q == GpAddr) begin
                arr_wdata = init_gp_i;
            end else begin
                arr_wdata = '0;
            end
        end else begin
            arr_we = run_active && wr_en_i && (wr_addr_i != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && arr_we) begin
            rf_q[arr_waddr] <= arr_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: independent registered outputs.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  rd_val;
        logic [WIDTH-1:0]  data_q, data_d;

        assign addr = rd_addr_i[g*ADDR_W +: ADDR_W];

        always_comb begin
            if (addr == '0) begin
                rd_val = '0;
`ifdef REGFILE_BYPASS_EN
            // A nonzero addr that matches wr_addr_i implies a nonzero write address.
            end else if (wr_en_i && (wr_addr_i == addr)) begin
                rd_val = wr_data_i;
`endif
            end else begin
                rd_val = rf_q[addr];
            end
        end

        always_comb begin
            data_d = data_q;
            if (!run_active) begin
                data_d = '0;
            end else if (rd_en_i[g]) begin
                data_d = rd_val;
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign rd_data_o[g*WIDTH +: WIDTH] = data_q;
    end

endmodule
